// File: rtl/mips32_pkg.sv
// Shared constants for the single-cycle MIPS32 subset core.
package mips32_pkg;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_ctrl_t;

  // Fixed program; unused words are 0, which decodes as sll $0 (a no-op).
  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    case (idx)
      6'd0:    rom_word = 32'h2001_0005;  // addi $1,$0,5
      6'd1:    rom_word = 32'h2002_0003;  // addi $2,$0,3
      6'd2:    rom_word = 32'h0022_1820;  // add  $3,$1,$2
      6'd3:    rom_word = 32'h0022_2022;  // sub  $4,$1,$2
      6'd4:    rom_word = 32'h0022_2824;  // and  $5,$1,$2
      6'd5:    rom_word = 32'h0022_3025;  // or   $6,$1,$2
      6'd6:    rom_word = 32'h0041_382A;  // slt  $7,$2,$1
      6'd7:    rom_word = 32'hAC00_0000;  // sw   $0,0($0)
      6'd8:    rom_word = 32'h8C08_0000;  // lw   $8,0($0)
      6'd9:    rom_word = 32'h1000_FFFF;  // beq  $0,$0,-1
      default: rom_word = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/mips32_cpu_data_memory.sv
// Word-addressed data RAM: combinational read, synchronous write, no reset.
module data_memory
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] ram [DMEM_WORDS] = '{default: 32'h0};

  // store on the edge that ends the sw cycle
  always_ff @(posedge clk) begin
    if (we) ram[addr] <= wdata;
  end

  assign rdata = ram[addr];

endmodule

// File: rtl/mips32_cpu.sv
// Single-cycle MIPS32 subset core: internal ROM, 32x32 register file, data RAM.
module mips32_cpu
  import mips32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result
);

  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wr_addr;
  logic [31:0] imm_sext, rs_val, rt_val, alu_b, alu_raw, wr_data, mem_rdata;
  logic [31:0] pc_plus4, pc_next;
  logic        reg_write, mem_write, mem_to_reg, alu_src_imm, branch, jump;
  alu_ctrl_t   alu_ctrl;

  assign instr    = rom_word(pc[7:2]);
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  assign rs_val = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : rf[rt];

  // instruction decode into datapath controls
  always_comb begin
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    wr_addr     = rd;
    alu_ctrl    = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        case (funct)
          FN_ADD:  alu_ctrl = ALU_ADD;
          FN_SUB:  alu_ctrl = ALU_SUB;
          FN_AND:  alu_ctrl = ALU_AND;
          FN_OR:   alu_ctrl = ALU_OR;
          FN_SLT:  alu_ctrl = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_write = 1'b1; alu_src_imm = 1'b1; wr_addr = rt;
      end
      OP_LW: begin
        reg_write = 1'b1; alu_src_imm = 1'b1; mem_to_reg = 1'b1; wr_addr = rt;
      end
      OP_SW: begin
        mem_write = 1'b1; alu_src_imm = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1; alu_ctrl = ALU_SUB;
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end

  assign alu_b = alu_src_imm ? imm_sext : rt_val;

  // ALU; j has no meaningful result so it is pinned to 0
  always_comb begin
    case (alu_ctrl)
      ALU_SUB: alu_raw = rs_val - alu_b;
      ALU_AND: alu_raw = rs_val & alu_b;
      ALU_OR:  alu_raw = rs_val | alu_b;
      ALU_SLT: alu_raw = {31'h0, $signed(rs_val) < $signed(alu_b)};
      default: alu_raw = rs_val + alu_b;
    endcase
    alu_result = jump ? 32'h0 : alu_raw;
  end

  data_memory dm (
    .clk   (clk),
    .we    (mem_write & ~reset),
    .addr  (alu_result[7:2]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign wr_data  = mem_to_reg ? mem_rdata : alu_result;
  assign pc_plus4 = pc + 32'd4;

  // next-PC select: jump, taken branch, or fall-through
  always_comb begin
    if (jump)
      pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && (alu_result == 32'h0))
      pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
    else
      pc_next = pc_plus4;
  end

  // program counter
  always_ff @(posedge clk) begin
    if (reset) pc <= 32'h0;
    else       pc <= pc_next;
  end

  // register file write port; $0 is never stored
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (reg_write && (wr_addr != 5'd0)) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign pc_out = pc;

endmodule

// File: tb/tb_mips32_cpu.sv
// Self-checking bench for mips32_cpu: fixed program, halt loop, mid-run reset, $0 writes.
module tb_mips32_cpu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out, alu_result;

  mips32_cpu dut (
    .clk        (clk),
    .reset      (reset),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
  } vec_t;

  vec_t        prog_tbl [10];
  vec_t        sb_q [$];
  logic [31:0] reg_exp [9];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Push the expectation, let the cycle settle, pop and compare at the falling edge.
  task automatic run_cycle(input vec_t v, input string tag);
    vec_t e;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    check({tag, " pc"}, pc_out, e.pc);
    check({tag, " alu"}, alu_result, e.alu);
    @(posedge clk);
    #1;
  endtask

  task automatic run_program(input int last, input string tag);
    for (int k = 0; k <= last; k++)
      run_cycle(prog_tbl[k], $sformatf("%s c%0d", tag, k));
  endtask

  initial begin
    vec_t halt_v, rst_v;
    prog_tbl[0] = '{32'h00, 32'd5};
    prog_tbl[1] = '{32'h04, 32'd3};
    prog_tbl[2] = '{32'h08, 32'd8};
    prog_tbl[3] = '{32'h0C, 32'd2};
    prog_tbl[4] = '{32'h10, 32'd1};
    prog_tbl[5] = '{32'h14, 32'd7};
    prog_tbl[6] = '{32'h18, 32'd1};
    prog_tbl[7] = '{32'h1C, 32'd0};
    prog_tbl[8] = '{32'h20, 32'd0};
    prog_tbl[9] = '{32'h24, 32'd0};
    reg_exp = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd0};
    halt_v  = '{32'h24, 32'd0};
    rst_v   = '{32'h00, 32'd5};

    // reset held 5 cycles
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) run_cycle(rst_v, $sformatf("reset c%0d", i));
    for (int r = 1; r < 9; r++) check($sformatf("reset r%0d", r), dut.rf[r], 32'h0);

    // run the program from cycle 0 (pc already 0 from the last reset edge)
    reset = 1'b0;
    run_program(9, "run1");
    for (int i = 0; i < 4; i++) check($sformatf("ram[%0d]", i), dut.dm.ram[i], 32'h0);
    for (int r = 1; r < 9; r++) check($sformatf("run1 r%0d", r), dut.rf[r], reg_exp[r]);

    // halt loop for 25 cycles, memory untouched
    for (int i = 0; i < 25; i++) run_cycle(halt_v, $sformatf("halt c%0d", i));
    for (int i = 0; i < 4; i++) check($sformatf("halt ram[%0d]", i), dut.dm.ram[i], 32'h0);

    // mid-program reset: rerun through cycle 4, then pulse reset for one edge
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_program(4, "pre");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 1; r < 9; r++) check($sformatf("midrst r%0d", r), dut.rf[r], 32'h0);
    run_program(9, "run2");
    for (int r = 1; r < 9; r++) check($sformatf("run2 r%0d", r), dut.rf[r], reg_exp[r]);
    check("run2 ram[0]", dut.dm.ram[0], 32'h0);

    // write attempt to $0 (add $0,$1,$2), then read $0 back via add $10,$0,$1
    force dut.instr = 32'h0022_0020;
    run_cycle('{32'h24, 32'd8}, "wr0");
    check("wr0 rf0", dut.rf[0], 32'h0);
    force dut.instr = 32'h0001_5020;
    run_cycle('{32'h28, 32'd5}, "rd0");
    release dut.instr;
    check("rd0 r10", dut.rf[10], 32'd5);
    check("rd0 rf0", dut.rf[0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
